layer_compositor: RTL and testbench
===================================

LAYER_COMPOSITOR -- requirements
Module: layer_compositor

Interface
REQ-001 Parameter NUM_LAYERS, default 4, number of drawing layers; index 0 is the player layer and has the highest priority.
REQ-002 Parameter BG_COLOR, default 8'h00, colour emitted when every layer is transparent.
REQ-003 clk  in  1  system clock; the block's only clock.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 vga_x  in  11  current pixel column from the VGA timing generator.
REQ-006 vga_y  in  11  current pixel row.
REQ-007 vga_de  in  1  active-video flag.
REQ-008 vga_hsync, vga_vsync  in  1 each  sync inputs.
REQ-009 requested_x, requested_y  out  11 each  coordinate broadcast to all layer controllers.
REQ-010 frame_start  out  1  one-cycle pulse that starts a frame for the layer controllers.
REQ-011 layer_color  in  NUM_LAYERS x 8  registered colour returned by each layer; MASK_VALUE means transparent.
REQ-012 rgb_out  out  8  composited pixel colour.
REQ-013 rgb_de, hsync_out, vsync_out  out  1 each  delayed timing signals aligned with rgb_out.
REQ-014 collision  out  NUM_LAYERS-1  bit k-1 set means the player overlapped layer k during the last frame.
REQ-015 collision_valid  out  1  one-cycle pulse when collision is updated.

Function
REQ-016 Stage 0 (cycle t): the block SHALL register vga_x, vga_y and vga_de.
  - At t+1 it SHALL drive these values on requested_x and requested_y.
REQ-017 Layers return layer_color for a request at t+2.
  - The block SHALL register the composited result so that rgb_out is valid at t+3.
  - Total latency from vga_x to rgb_out SHALL be exactly 3 cycles.
REQ-018 rgb_de, hsync_out and vsync_out SHALL equal vga_de, vga_hsync and vga_vsync delayed by exactly 3 cycles.
REQ-019 Compositing SHALL select the lowest-index layer whose colour is not MASK_VALUE (8'h62).
  - If every layer equals MASK_VALUE, the result SHALL be BG_COLOR.
REQ-020 When the delayed de is 0, rgb_out SHALL be 8'h00, regardless of layer colours.
REQ-021 frame_start SHALL pulse for exactly one cycle, the cycle after vga_de=1 is sampled with vga_x=0 and vga_y=0.
  - It SHALL be edge-qualified: holding (0,0,de=1) for several cycles SHALL produce only one pulse.
  - A new pulse SHALL be allowed only after the stage-0 coordinate has left (0,0).
REQ-022 A sticky register, NUM_LAYERS-1 bits wide, SHALL track collisions.
  - Bit k-1 SHALL set at the composite stage when delayed de=1, layer_color[0] is not MASK_VALUE and layer_color[k] is not MASK_VALUE.
REQ-023 On each frame_start pulse:
  - collision SHALL load the sticky value and collision_valid SHALL pulse for one cycle.
  - The sticky register SHALL clear, except for hits detected in that same cycle, which SHALL be retained for the new frame.
REQ-024 collision SHALL hold its value between frame_start pulses.
REQ-025 Coordinates SHALL pass through unmodified at 11 bits: no arithmetic and no wrap.

Reset
REQ-026 While reset=1 at a clk edge, the block SHALL clear:
  - the pipeline registers, delay lines and sticky register;
  - requested_x, requested_y, rgb_out, rgb_de, hsync_out, vsync_out, frame_start, collision and collision_valid.
REQ-027 A reset asserted mid-frame SHALL discard in-flight pixels.
  - The first valid rgb_out SHALL appear 3 cycles after the first post-reset sample.
  - The frame_start edge detector SHALL re-arm, so a (0,0) sample right after reset produces a pulse.

Structure
REQ-028 A shared package compositor_pkg SHALL hold:
  - MASK_VALUE = 8'h62;
  - the coordinate width (11);
  - a color_t typedef (8-bit);
  - the layer-state index constants (img_id, x, y, width, height).
REQ-029 The 3-cycle timing delay SHALL be a single sub-module pipe_delay, parameterised by width and depth, instantiated once for {de, hsync, vsync}.

Verification
REQ-030 Pass-through: drive vga_x=100, vga_y=50, de=1 at cycle t -> requested_x=100 and requested_y=50 at t+1; rgb_de=1 at t+3.
REQ-031 Priority: at the composite stage layer_color={8'h62, 8'h1C, 8'hE0, 8'h62} -> rgb_out=8'h1C; all four layers 8'h62 -> rgb_out=BG_COLOR.
REQ-032 Blanking: de=0 with layer_color[1]=8'hFF -> rgb_out=8'h00 and rgb_de=0 exactly 3 cycles later.
REQ-033 Frame pulse: hold (0,0,de=1) for 4 cycles -> exactly one frame_start pulse; step to (1,0), then through a full frame back to (0,0) -> a second pulse.
REQ-034 Collision across frames:
  - Frame N: layer0=8'h03 and layer2=8'h40 on one active pixel -> at the next frame_start, collision=3'b010 and collision_valid pulses once.
  - Frame N+1 with no overlap -> collision=3'b000 at the following pulse.
REQ-035 Reset mid-operation: assert reset for 1 cycle during active video -> all outputs 0 on the next cycle; valid output resumes 3 cycles after de returns.

Source files
------------

// File: rtl/compositor_pkg.sv
// rtl/compositor_pkg.sv - shared constants and types for the layer compositor
// Purpose: colour type, transparency key, coordinate width and the layer-state
//          field indices used by the layer controllers.
// Ports:   none (package).
package compositor_pkg;

    localparam int COORD_W = 11;
    localparam int COLOR_W = 8;

    typedef logic [COLOR_W-1:0] color_t;

    // Colour a layer returns to mean "nothing drawn here".
    localparam color_t MASK_VALUE = 8'h62;

    // Field indices into a layer controller's state record.
    localparam int LS_IMG_ID     = 0;
    localparam int LS_X          = 1;
    localparam int LS_Y          = 2;
    localparam int LS_WIDTH      = 3;
    localparam int LS_HEIGHT     = 4;
    localparam int LS_NUM_FIELDS = 5;

    function automatic logic is_opaque(input color_t c);
        return c != MASK_VALUE;
    endfunction

endpackage

// File: rtl/pipe_delay.sv
// rtl/pipe_delay.sv - fixed-depth register delay line with synchronous clear
// Purpose: delays a WIDTH-bit bundle by exactly DEPTH clock cycles.
// Ports:   clk, reset (sync, active-high), data_i (input bundle),
//          data_o (bundle as it was DEPTH cycles earlier).
module pipe_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= data_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign data_o = stage_q[DEPTH-1];

endmodule

// File: rtl/layer_compositor.sv
// rtl/layer_compositor.sv - priority compositor for stacked drawing layers
// Purpose: broadcasts the current pixel coordinate to the layer controllers,
//          picks the highest-priority opaque layer colour, aligns the VGA
//          timing with it, and reports per-frame player collisions.
// Ports:   clk, reset (sync, active-high);
//          vga_x/vga_y/vga_de/vga_hsync/vga_vsync - timing generator inputs;
//          requested_x/requested_y, frame_start - to the layer controllers;
//          layer_color - layer k colour at bits [k*8 +: 8], layer 0 = player;
//          rgb_out, rgb_de, hsync_out, vsync_out - composited pixel stream;
//          collision, collision_valid - per-frame player overlap report.
module layer_compositor
    import compositor_pkg::*;
#(
    parameter int     NUM_LAYERS = 4,
    parameter color_t BG_COLOR   = 8'h00
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [COORD_W-1:0]            vga_x,
    input  logic [COORD_W-1:0]            vga_y,
    input  logic                          vga_de,
    input  logic                          vga_hsync,
    input  logic                          vga_vsync,
    output logic [COORD_W-1:0]            requested_x,
    output logic [COORD_W-1:0]            requested_y,
    output logic                          frame_start,
    input  logic [NUM_LAYERS*COLOR_W-1:0] layer_color,
    output logic [COLOR_W-1:0]            rgb_out,
    output logic                          rgb_de,
    output logic                          hsync_out,
    output logic                          vsync_out,
    output logic [NUM_LAYERS-2:0]         collision,
    output logic                          collision_valid
);

    logic [COORD_W-1:0]    x_q, y_q;
    logic                  de_q;
    logic                  de_c_q;      // de of the pixel now at the composite stage
    color_t                rgb_q, rgb_d;
    color_t                pick;
    logic [NUM_LAYERS-2:0] hits;
    logic                  at_origin;
    logic                  frame_start_q, frame_start_d;
    logic                  armed_q, armed_d;
    logic [NUM_LAYERS-2:0] sticky_q, sticky_d;
    logic [NUM_LAYERS-2:0] collision_q, collision_d;
    logic                  collision_valid_q;
    logic [2:0]            timing_dly;

    pipe_delay #(
        .WIDTH (3),
        .DEPTH (3)
    ) u_timing_delay (
        .clk    (clk),
        .reset  (reset),
        .data_i ({vga_de, vga_hsync, vga_vsync}),
        .data_o (timing_dly)
    );

    // Composite stage: scan from the lowest priority upwards so the last
    // opaque layer written (lowest index) wins.
    always_comb begin
        pick = BG_COLOR;
        for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
            if (is_opaque(layer_color[k*COLOR_W +: COLOR_W])) begin
                pick = layer_color[k*COLOR_W +: COLOR_W];
            end
        end
        hits = '0;
        for (int k = 1; k < NUM_LAYERS; k++) begin
            hits[k-1] = de_c_q
                      && is_opaque(layer_color[0 +: COLOR_W])
                      && is_opaque(layer_color[k*COLOR_W +: COLOR_W]);
        end
        rgb_d = de_c_q ? pick : '0;
    end

    // Frame start fires on the first active (0,0) sample; it re-arms only
    // once a sample away from the origin has been seen.
    always_comb begin
        at_origin     = (vga_x == '0) && (vga_y == '0);
        frame_start_d = vga_de && at_origin && armed_q;
        armed_d       = armed_q;
        if (!at_origin) begin
            armed_d = 1'b1;
        end else if (frame_start_d) begin
            armed_d = 1'b0;
        end
    end

    // Hits seen in the same cycle as the frame boundary belong to the new frame.
    always_comb begin
        collision_d = collision_q;
        sticky_d    = sticky_q | hits;
        if (frame_start_d) begin
            collision_d = sticky_q;
            sticky_d    = hits;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q               <= '0;
            y_q               <= '0;
            de_q              <= 1'b0;
            de_c_q            <= 1'b0;
            rgb_q             <= '0;
            frame_start_q     <= 1'b0;
            armed_q           <= 1'b1;
            sticky_q          <= '0;
            collision_q       <= '0;
            collision_valid_q <= 1'b0;
        end else begin
            x_q               <= vga_x;
            y_q               <= vga_y;
            de_q              <= vga_de;
            de_c_q            <= de_q;
            rgb_q             <= rgb_d;
            frame_start_q     <= frame_start_d;
            armed_q           <= armed_d;
            sticky_q          <= sticky_d;
            collision_q       <= collision_d;
            collision_valid_q <= frame_start_d;
        end
    end

    assign requested_x     = x_q;
    assign requested_y     = y_q;
    assign frame_start     = frame_start_q;
    assign rgb_out         = rgb_q;
    assign {rgb_de, hsync_out, vsync_out} = timing_dly;
    assign collision       = collision_q;
    assign collision_valid = collision_valid_q;

endmodule

// File: tb/tb_layer_compositor.sv
// tb/tb_layer_compositor.sv - self-checking bench for layer_compositor
module tb_layer_compositor;
    import compositor_pkg::*;

    localparam int     NL   = 4;
    localparam color_t BG   = 8'h5A;
    localparam int     MAXC = 8192;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [10:0]     vga_x = '0, vga_y = '0;
    logic            vga_de = 1'b0, vga_hsync = 1'b0, vga_vsync = 1'b0;
    logic [10:0]     requested_x, requested_y;
    logic            frame_start;
    logic [NL*8-1:0] layer_color;
    logic [7:0]      rgb_out;
    logic            rgb_de, hsync_out, vsync_out;
    logic [NL-2:0]   collision;
    logic            collision_valid;

    color_t col [NL];

    always_comb begin
        layer_color = '0;
        for (int k = 0; k < NL; k++) begin
            layer_color[k*8 +: 8] = col[k];
        end
    end

    layer_compositor #(
        .NUM_LAYERS (NL),
        .BG_COLOR   (BG)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .vga_x           (vga_x),
        .vga_y           (vga_y),
        .vga_de          (vga_de),
        .vga_hsync       (vga_hsync),
        .vga_vsync       (vga_vsync),
        .requested_x     (requested_x),
        .requested_y     (requested_y),
        .frame_start     (frame_start),
        .layer_color     (layer_color),
        .rgb_out         (rgb_out),
        .rgb_de          (rgb_de),
        .hsync_out       (hsync_out),
        .vsync_out       (vsync_out),
        .collision       (collision),
        .collision_valid (collision_valid)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int n = 0;
    int pulses = 0;

    // Per-cycle input history for the reference model.
    logic hde [MAXC];
    logic hhs [MAXC];
    logic hvs [MAXC];
    logic hrst [MAXC];

    // Frame-level model state.
    bit            m_armed = 1'b1;
    logic [NL-2:0] m_sticky = '0;
    logic [NL-2:0] m_coll = '0;
    logic [NL-2:0] last_coll = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, n, got, exp);
        end
    endtask

    // A value sampled in cycle m reaches an output only if no reset edge
    // occurred from m through last.
    function automatic bit survive(input int m, input int last);
        if (m < 0) return 1'b0;
        for (int i = m; i <= last; i++) begin
            if (hrst[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic set_cols(input color_t c0, input color_t c1, input color_t c2, input color_t c3);
        col[0] = c0; col[1] = c1; col[2] = c2; col[3] = c3;
    endtask

    task automatic step(input logic [10:0] x, input logic [10:0] y,
                        input logic de, input logic hs, input logic vs, input logic rst);
        color_t        e_rgb, pick;
        logic          e_de, e_hs, e_vs, cde, e_fs, e_cv;
        logic [NL-2:0] hits;
        bit            found;
        vga_x = x; vga_y = y; vga_de = de; vga_hsync = hs; vga_vsync = vs; reset = rst;
        hde[n] = de; hhs[n] = hs; hvs[n] = vs; hrst[n] = rst;

        e_de = 1'b0; e_hs = 1'b0; e_vs = 1'b0; cde = 1'b0;
        if (n >= 2 && survive(n - 2, n)) begin
            e_de = hde[n-2]; e_hs = hhs[n-2]; e_vs = hvs[n-2];
        end
        if (n >= 2 && survive(n - 2, n - 1)) cde = hde[n-2];

        pick = BG; found = 1'b0;
        for (int k = 0; k < NL; k++) begin
            if (!found && col[k] != MASK_VALUE) begin
                pick = col[k];
                found = 1'b1;
            end
        end
        hits = '0;
        for (int k = 1; k < NL; k++) begin
            hits[k-1] = cde && (col[0] != MASK_VALUE) && (col[k] != MASK_VALUE);
        end
        e_rgb = (!rst && cde) ? pick : '0;
        e_fs  = !rst && de && (x == '0) && (y == '0) && m_armed;
        if (rst) begin
            m_armed = 1'b1; m_sticky = '0; m_coll = '0; e_cv = 1'b0;
        end else begin
            if (x != '0 || y != '0) m_armed = 1'b1;
            else if (e_fs) m_armed = 1'b0;
            e_cv = e_fs;
            if (e_fs) begin
                m_coll = m_sticky;
                m_sticky = hits;
            end else begin
                m_sticky = m_sticky | hits;
            end
        end

        @(posedge clk);
        #1;
        check("requested_x", 32'(requested_x), rst ? 32'd0 : 32'(x));
        check("requested_y", 32'(requested_y), rst ? 32'd0 : 32'(y));
        check("rgb_out", 32'(rgb_out), 32'(e_rgb));
        check("rgb_de", 32'(rgb_de), 32'(e_de));
        check("hsync_out", 32'(hsync_out), 32'(e_hs));
        check("vsync_out", 32'(vsync_out), 32'(e_vs));
        check("frame_start", 32'(frame_start), 32'(e_fs));
        check("collision", 32'(collision), 32'(m_coll));
        check("collision_valid", 32'(collision_valid), 32'(e_cv));
        if (frame_start === 1'b1) begin
            pulses++;
            last_coll = collision;
        end
        n++;
    endtask

    // Small raster: 8x4, active for x<6; ends on the next frame's origin.
    task automatic run_frame(input bit overlap);
        for (int yy = 0; yy < 4; yy++) begin
            for (int xx = 0; xx < 8; xx++) begin
                if (yy == 0 && xx == 0) continue;
                set_cols(MASK_VALUE, 8'($urandom), 8'($urandom), 8'($urandom));
                if (overlap && yy == 1 && xx == 4) begin
                    set_cols(8'h03, MASK_VALUE, 8'h40, MASK_VALUE);
                end
                step(11'(xx), 11'(yy), xx < 6, xx == 7, yy == 3, 1'b0);
            end
        end
        set_cols(MASK_VALUE, MASK_VALUE, MASK_VALUE, MASK_VALUE);
        step(11'd0, 11'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        set_cols(MASK_VALUE, MASK_VALUE, MASK_VALUE, MASK_VALUE);

        step(11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(11'd7, 11'd3, 1'b1, 1'b1, 1'b1, 1'b1);
        check("reset_rgb", 32'(rgb_out), 32'd0);
        check("reset_collision", 32'(collision), 32'd0);

        step(11'd100, 11'd50, 1'b1, 1'b0, 1'b0, 1'b0);
        check("pass_req_x", 32'(requested_x), 32'd100);
        check("pass_req_y", 32'(requested_y), 32'd50);
        step(11'd101, 11'd50, 1'b1, 1'b0, 1'b0, 1'b0);
        step(11'd102, 11'd50, 1'b1, 1'b0, 1'b0, 1'b0);
        check("pass_rgb_de", 32'(rgb_de), 32'd1);

        step(11'd5, 11'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        step(11'd6, 11'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        set_cols(8'h62, 8'h1C, 8'hE0, 8'h62);
        step(11'd7, 11'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        check("prio_1c", 32'(rgb_out), 32'h1C);
        set_cols(MASK_VALUE, MASK_VALUE, MASK_VALUE, MASK_VALUE);
        step(11'd8, 11'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        check("prio_bg", 32'(rgb_out), 32'(BG));

        step(11'd9, 11'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        step(11'd10, 11'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        set_cols(MASK_VALUE, 8'hFF, MASK_VALUE, MASK_VALUE);
        step(11'd11, 11'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        check("blank_rgb", 32'(rgb_out), 32'd0);
        check("blank_de", 32'(rgb_de), 32'd0);

        set_cols(MASK_VALUE, MASK_VALUE, MASK_VALUE, MASK_VALUE);
        pulses = 0;
        repeat (4) step(11'd0, 11'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("hold_origin_pulses", 32'(pulses), 32'd1);
        run_frame(1'b0);
        check("frame_pulses", 32'(pulses), 32'd2);

        run_frame(1'b1);
        check("coll_frame_n", 32'(last_coll), 32'b010);
        run_frame(1'b0);
        check("coll_frame_n1", 32'(last_coll), 32'b000);

        step(11'd0, 11'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(11'd0, 11'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        check("midrst_rgb", 32'(rgb_out), 32'd0);
        check("midrst_de", 32'(rgb_de), 32'd0);
        check("midrst_fs", 32'(frame_start), 32'd0);
        step(11'd0, 11'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("rearm_pulse", 32'(frame_start), 32'd1);
        step(11'd1, 11'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(11'd2, 11'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("resume_de", 32'(rgb_de), 32'd1);

        for (int i = 0; i < 1500; i++) begin
            for (int k = 0; k < NL; k++) begin
                col[k] = ($urandom_range(0, 1) == 0) ? MASK_VALUE : 8'($urandom);
            end
            step(11'($urandom_range(0, 3)), 11'($urandom_range(0, 2)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 99) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cycle=%0d got=timeout expected=finish", n);
        $fatal(1, "watchdog expired");
    end

endmodule
